// File: rtl/menu_nav_controller.sv
// rtl/menu_nav_controller.sv - main-menu button debounce, selection FSM and screen/launch control
module menu_nav_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        btn_back,
    input  logic        game_over,
    output logic [28:0] metadata,
    output logic [2:0]  sel,
    output logic [1:0]  screen,
    output logic        start_game,
    output logic [2:0]  game_mode
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       SCR_MENU   = 2'd0;
    localparam logic [1:0]       SCR_GAME   = 2'd1;
    localparam logic [1:0]       SCR_SCORES = 2'd2;

    // Button bit positions inside the packed vectors below
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_ENTER = 4;
    localparam int B_BACK  = 5;

    logic [5:0]       raw;
    logic [5:0]       sync1_q, sync1_d;
    logic [5:0]       sync2_q, sync2_d;
    logic [5:0]       deb_q, deb_d;
    logic [5:0]       deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] cnt_q [6];
    logic [CNT_W-1:0] cnt_d [6];
    logic [5:0]       strobe;
    logic [5:0]       act;

    logic [2:0]       sel_q, sel_d;
    logic [1:0]       screen_q, screen_d;
    logic             start_q, start_d;
    logic [2:0]       mode_q, mode_d;
    logic [28:0]      meta_q, meta_d;

    assign raw = {btn_back, btn_enter, btn_right, btn_left, btn_down, btn_up};

    // Synchronize, debounce and delay the debounced level for edge detection
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press strobes, reduced to a single winner: enter > back > up > down > left > right
    always_comb begin
        strobe = deb_q & ~deb_prev_q;
        act    = '0;
        if (strobe[B_ENTER])      act[B_ENTER] = 1'b1;
        else if (strobe[B_BACK])  act[B_BACK]  = 1'b1;
        else if (strobe[B_UP])    act[B_UP]    = 1'b1;
        else if (strobe[B_DOWN])  act[B_DOWN]  = 1'b1;
        else if (strobe[B_LEFT])  act[B_LEFT]  = 1'b1;
        else if (strobe[B_RIGHT]) act[B_RIGHT] = 1'b1;
    end

    // State register: input path, screen FSM and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
            sel_q      <= '0;
            screen_q   <= SCR_MENU;
            start_q    <= 1'b0;
            mode_q     <= '0;
            meta_q     <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
            sel_q      <= sel_d;
            screen_q   <= screen_d;
            start_q    <= start_d;
            mode_q     <= mode_d;
            meta_q     <= meta_d;
        end
    end

    // Next-state: menu navigation (left column 0-2, right column 3-4), launch and screen changes
    always_comb begin
        sel_d    = sel_q;
        screen_d = screen_q;
        mode_d   = mode_q;
        start_d  = 1'b0;
        if (sel_q > 3'd4 || screen_q == 2'd3) begin
            sel_d    = '0;
            screen_d = SCR_MENU;
        end else begin
            case (screen_q)
                SCR_MENU: begin
                    if (act[B_ENTER]) begin
                        if (sel_q <= 3'd2) begin
                            mode_d   = sel_q;
                            start_d  = 1'b1;
                            screen_d = SCR_GAME;
                        end else begin
                            screen_d = SCR_SCORES;
                        end
                    end else if (act[B_UP]) begin
                        case (sel_q)
                            3'd1:    sel_d = 3'd0;
                            3'd2:    sel_d = 3'd1;
                            3'd4:    sel_d = 3'd3;
                            default: sel_d = sel_q;
                        endcase
                    end else if (act[B_DOWN]) begin
                        case (sel_q)
                            3'd0:    sel_d = 3'd1;
                            3'd1:    sel_d = 3'd2;
                            3'd3:    sel_d = 3'd4;
                            default: sel_d = sel_q;
                        endcase
                    end else if (act[B_LEFT]) begin
                        case (sel_q)
                            3'd3:    sel_d = 3'd0;
                            3'd4:    sel_d = 3'd1;
                            default: sel_d = sel_q;
                        endcase
                    end else if (act[B_RIGHT]) begin
                        case (sel_q)
                            3'd0:    sel_d = 3'd3;
                            3'd1:    sel_d = 3'd4;
                            3'd2:    sel_d = 3'd4;
                            default: sel_d = sel_q;
                        endcase
                    end
                end
                SCR_GAME: begin
                    if (game_over) screen_d = SCR_MENU;
                end
                SCR_SCORES: begin
                    if (act[B_ENTER] || act[B_BACK]) screen_d = SCR_MENU;
                end
                default: begin
                    sel_d    = '0;
                    screen_d = SCR_MENU;
                end
            endcase
        end
        meta_d = {sel_d, screen_d, 24'd0};
    end

    // Outputs straight from the registers
    always_comb begin
        sel        = sel_q;
        screen     = screen_q;
        start_game = start_q;
        game_mode  = mode_q;
        metadata   = meta_q;
    end

endmodule

// File: tb/tb_menu_nav_controller.sv
// tb/tb_menu_nav_controller.sv - table-driven scoreboard bench for menu_nav_controller
module tb_menu_nav_controller;

    localparam logic [6:0] M_UP = 7'h01;
    localparam logic [6:0] M_DN = 7'h02;
    localparam logic [6:0] M_LF = 7'h04;
    localparam logic [6:0] M_RT = 7'h08;
    localparam logic [6:0] M_EN = 7'h10;
    localparam logic [6:0] M_BK = 7'h20;
    localparam logic [6:0] M_GO = 7'h40;

    typedef struct {
        logic [6:0] mask;
        logic [2:0] sel;
        logic [1:0] scr;
        logic       start;
        logic [2:0] mode;
    } step_t;

    logic        clock;
    logic        resetn;
    logic [5:0]  btns;
    logic        game_over;
    logic [28:0] metadata;
    logic [2:0]  sel;
    logic [1:0]  screen;
    logic        start_game;
    logic [2:0]  game_mode;

    int    n_total;
    int    n_pass;
    int    start_cnt;
    step_t sb[$];
    step_t tbl[$];
    step_t exp_cur;

    menu_nav_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clock(clock),
        .resetn(resetn),
        .btn_up(btns[0]),
        .btn_down(btns[1]),
        .btn_left(btns[2]),
        .btn_right(btns[3]),
        .btn_enter(btns[4]),
        .btn_back(btns[5]),
        .game_over(game_over),
        .metadata(metadata),
        .sel(sel),
        .screen(screen),
        .start_game(start_game),
        .game_mode(game_mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetn && start_game) start_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic step_t mk(input logic [6:0] m, input logic [2:0] s, input logic [1:0] c,
                                 input logic st, input logic [2:0] md);
        step_t r;
        r.mask = m; r.sel = s; r.scr = c; r.start = st; r.mode = md;
        return r;
    endfunction

    task automatic run_step(input step_t s, input bit rel_reset);
        step_t e;
        int    sc0;
        @(negedge clock);
        if (rel_reset) resetn = 1'b1;
        sc0 = start_cnt;
        sb.push_back(s);
        if (s.mask[6]) begin
            game_over = 1'b1;
            @(posedge clock); #1;
            game_over = 1'b0;
        end else begin
            btns = btns | s.mask[5:0];
            repeat (6) @(posedge clock);
            #1;
            chk("sel_before_latency", 32'(sel), 32'(exp_cur.sel));
            chk("screen_before_latency", 32'(screen), 32'(exp_cur.scr));
            @(posedge clock); #1;
        end
        e = sb.pop_front();
        chk("sel", 32'(sel), 32'(e.sel));
        chk("screen", 32'(screen), 32'(e.scr));
        chk("start_game", 32'(start_game), 32'(e.start));
        chk("game_mode", 32'(game_mode), 32'(e.mode));
        chk("metadata", 32'(metadata), 32'({e.sel, e.scr, 24'd0}));
        @(posedge clock); #1;
        chk("start_after", 32'(start_game), 32'd0);
        chk("start_pulses", 32'(start_cnt - sc0), 32'(e.start));
        exp_cur = e;
        if (!s.mask[6]) begin
            @(negedge clock);
            btns = btns & ~s.mask[5:0];
            repeat (10) @(posedge clock);
        end
    endtask

    initial begin
        int sc_rel;
        n_total = 0; n_pass = 0; start_cnt = 0;
        resetn = 1'b0; btns = '0; game_over = 1'b0;
        exp_cur = mk(7'h0, 3'd0, 2'd0, 1'b0, 3'd0);

        tbl.push_back(mk(M_DN, 3'd1, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_DN, 3'd2, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_DN, 3'd2, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_UP, 3'd1, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_UP, 3'd0, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_UP, 3'd0, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_RT, 3'd3, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_RT, 3'd3, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_DN, 3'd4, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_DN, 3'd4, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_LF, 3'd1, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_DN, 3'd2, 2'd0, 1'b0, 3'd0));
        tbl.push_back(mk(M_EN, 3'd2, 2'd1, 1'b1, 3'd2));
        tbl.push_back(mk(M_UP, 3'd2, 2'd1, 1'b0, 3'd2));
        tbl.push_back(mk(M_EN, 3'd2, 2'd1, 1'b0, 3'd2));
        tbl.push_back(mk(M_GO, 3'd2, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_GO, 3'd2, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_RT, 3'd4, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_EN, 3'd4, 2'd2, 1'b0, 3'd2));
        tbl.push_back(mk(M_GO, 3'd4, 2'd2, 1'b0, 3'd2));
        tbl.push_back(mk(M_LF, 3'd4, 2'd2, 1'b0, 3'd2));
        tbl.push_back(mk(M_BK, 3'd4, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_BK, 3'd4, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_EN, 3'd4, 2'd2, 1'b0, 3'd2));
        tbl.push_back(mk(M_EN, 3'd4, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_LF, 3'd1, 2'd0, 1'b0, 3'd2));
        tbl.push_back(mk(M_UP | M_EN, 3'd1, 2'd1, 1'b1, 3'd1));
        tbl.push_back(mk(M_GO, 3'd1, 2'd0, 1'b0, 3'd1));

        // Reset state and idle period
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_screen", 32'(screen), 32'd0);
        chk("reset_metadata", 32'(metadata), 32'd0);
        chk("reset_game_mode", 32'(game_mode), 32'd0);
        repeat (100) @(posedge clock);
        #1;
        chk("idle_start_pulses", 32'(start_cnt), 32'd0);
        chk("idle_sel", 32'(sel), 32'd0);

        // Three-cycle glitch on right must not qualify
        @(negedge clock);
        btns[3] = 1'b1;
        repeat (3) @(negedge clock);
        btns[3] = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk("glitch_sel", 32'(sel), 32'd0);
        chk("glitch_metadata", 32'(metadata), 32'd0);

        foreach (tbl[i]) run_step(tbl[i], 1'b0);

        // Reset during the debounce of a second launch, enter held across release
        @(negedge clock);
        btns[4] = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("midreset_sel", 32'(sel), 32'd0);
        chk("midreset_screen", 32'(screen), 32'd0);
        chk("midreset_start", 32'(start_game), 32'd0);
        chk("midreset_game_mode", 32'(game_mode), 32'd0);
        chk("midreset_metadata", 32'(metadata), 32'd0);
        exp_cur = mk(7'h0, 3'd0, 2'd0, 1'b0, 3'd0);
        repeat (3) @(posedge clock);
        sc_rel = start_cnt;
        run_step(mk(M_EN, 3'd0, 2'd1, 1'b1, 3'd0), 1'b1);
        repeat (20) @(posedge clock);
        #1;
        chk("post_release_launches", 32'(start_cnt - sc_rel), 32'd1);
        chk("post_release_screen", 32'(screen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
